// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit for the E stage of the five-stage MIPS pipeline.
//
// Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo against the
// architectural HI/LO registers. Multiply and divide results are computed in
// full on the issue edge and parked in a pending register. A countdown then
// models the unit's latency before the result is committed to HI/LO.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - asynchronous, active-low reset
//   start  - E stage holds a valid md/mt/mf instruction this cycle
//   op     - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//            7 mfhi, 8 mflo, 9-15 none
//   src_a  - forwarded rs value
//   src_b  - forwarded rt value
//   req    - exception/interrupt this cycle; the E-stage instruction is flushed
//   busy   - unit occupied; D stage stalls any md/mt/mf (MDUBusy)
//   out    - mfhi/mflo read data (MDUOut)
//   hi, lo - architectural HI and LO
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    // Cleared for a divide by zero so the commit leaves HI/LO untouched.
    logic              pend_valid_q, pend_valid_d;

    logic signed [63:0] mul_s;
    logic [63:0]        mul_u;
    logic signed [63:0] div_num_s;
    logic signed [63:0] div_den_s;
    logic [31:0]        div_den_u;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;
    logic               div_by_zero;

    assign mul_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign mul_u = {32'b0, src_a} * {32'b0, src_b};

    // Signed division is done at 64 bits so 0x80000000 / -1 yields a quotient
    // of +2^31 whose low word is 0x80000000, instead of overflowing. A zero
    // divisor is replaced by 1; its result is discarded anyway.
    assign div_by_zero = (src_b == 32'd0);
    assign div_num_s   = $signed({{32{src_a[31]}}, src_a});
    assign div_den_s   = div_by_zero ? 64'sd1 : $signed({{32{src_b[31]}}, src_b});
    assign div_den_u   = div_by_zero ? 32'd1 : src_b;
    assign quo_s       = 32'(div_num_s / div_den_s);
    assign rem_s       = 32'(div_num_s % div_den_s);
    assign quo_u       = src_a / div_den_u;
    assign rem_u       = src_a % div_den_u;

    // Next-state logic: issues only in IDLE and only when not flushed by req;
    // in RUN the counter runs down and the zero count commits the result.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        case (state_q)
            IDLE: begin
                if (start && !req) begin
                    case (op)
                        OP_MULT: begin
                            pend_hi_d    = mul_s[63:32];
                            pend_lo_d    = mul_s[31:0];
                            pend_valid_d = 1'b1;
                            cnt_d        = MULT_LOAD;
                            state_d      = RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_d    = mul_u[63:32];
                            pend_lo_d    = mul_u[31:0];
                            pend_valid_d = 1'b1;
                            cnt_d        = MULT_LOAD;
                            state_d      = RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d    = rem_s;
                            pend_lo_d    = quo_s;
                            pend_valid_d = !div_by_zero;
                            cnt_d        = DIV_LOAD;
                            state_d      = RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d    = rem_u;
                            pend_lo_d    = quo_u;
                            pend_valid_d = !div_by_zero;
                            cnt_d        = DIV_LOAD;
                            state_d      = RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (pend_valid_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // The issue term is combinational so the hazard unit sees the unit as
    // occupied in the very cycle an md instruction sits in E.
    assign busy = (state_q == RUN) ||
                  (start && !req && (op >= OP_MULT) && (op <= OP_DIVU));

    // Reads are not gated by start; during RUN they return the old HI/LO.
    always_comb begin
        out = 32'd0;
        case (op)
            OP_MFHI: out = hi_q;
            OP_MFLO: out = lo_q;
            default: out = 32'd0;
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit.
//
// Expected HI/LO values come from a behavioural model using plain 64-bit
// arithmetic (division via magnitudes and explicit sign rules). Each
// scenario task drives stimulus and compares DUT outputs inline. Inputs are
// driven 1 ns after a rising edge; outputs are sampled on falling edges.
module tb_mdu_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        req;
    logic        busy;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    int          assertions = 0;
    int          failures   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .src_a(src_a),
        .src_b(src_b),
        .req  (req),
        .busy (busy),
        .out  (out),
        .hi   (hi),
        .lo   (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural result of an md op; upd=0 means HI/LO stay unchanged.
    function automatic void model_md(input logic [3:0] o, input logic [31:0] a,
                                     input logic [31:0] b, output bit upd,
                                     output logic [31:0] mh, output logic [31:0] ml);
        longint sa, sb, ma, mb, p, q, r;
        longint unsigned ua, ub, up;
        upd = 1'b1;
        mh  = 32'd0;
        ml  = 32'd0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (o)
            4'd1: begin
                p  = sa * sb;
                mh = p[63:32];
                ml = p[31:0];
            end
            4'd2: begin
                up = ua * ub;
                mh = up[63:32];
                ml = up[31:0];
            end
            4'd3: begin
                if (b == 32'd0) begin
                    upd = 1'b0;
                end else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    r  = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    ml = q[31:0];
                    mh = r[31:0];
                end
            end
            4'd4: begin
                if (b == 32'd0) begin
                    upd = 1'b0;
                end else begin
                    ml = a / b;
                    mh = a % b;
                end
            end
            default: upd = 1'b0;
        endcase
    endfunction

    // Issue one md op and follow it through busy, in-run reads and commit.
    task automatic test_md_op(input logic [3:0] o, input logic [31:0] a,
                              input logic [31:0] b, input string name);
        logic [31:0] exp_hi, exp_lo;
        bit          upd;
        int          n;
        model_md(o, a, b, upd, exp_hi, exp_lo);
        n     = (o <= 4'd2) ? MULT_CYCLES : DIV_CYCLES;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        req   = 1'b0;
        @(negedge clk);
        assertions++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s busy_issue: got %0b expected 1", name, busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd7;
        src_a = $urandom;
        src_b = $urandom;
        for (int i = 0; i < n; i++) begin
            req = 1'($urandom_range(0, 1));
            @(negedge clk);
            assertions++;
            if (busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s busy_run[%0d]: got %0b expected 1", name, i, busy);
            end
            assertions++;
            if (out !== hi_m) begin
                failures++;
                $display("[TB] FAIL %s out_in_run[%0d]: got %h expected %h", name, i, out, hi_m);
            end
            assertions++;
            if (lo !== lo_m) begin
                failures++;
                $display("[TB] FAIL %s lo_in_run[%0d]: got %h expected %h", name, i, lo, lo_m);
            end
        end
        req = 1'b0;
        if (upd) begin
            hi_m = exp_hi;
            lo_m = exp_lo;
        end
        @(negedge clk);
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s busy_done: got %0b expected 0", name, busy);
        end
        assertions++;
        if (hi !== hi_m) begin
            failures++;
            $display("[TB] FAIL %s hi_commit: got %h expected %h", name, hi, hi_m);
        end
        assertions++;
        if (lo !== lo_m) begin
            failures++;
            $display("[TB] FAIL %s lo_commit: got %h expected %h", name, lo, lo_m);
        end
        @(posedge clk);
        #1;
        op = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        req   = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
        end
        assertions++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", hi, lo);
        end
        op = 4'd7;
        #1;
        assertions++;
        if (out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_out: got %h expected 0", out);
        end
        op = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult();
        test_md_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    endtask

    task automatic test_multu();
        test_md_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
        start = 1'b1;
        op    = 4'd7;
        #1;
        assertions++;
        if (out !== hi_m) begin
            failures++;
            $display("[TB] FAIL mfhi_out: got %h expected %h", out, hi_m);
        end
        start = 1'b0;
        op    = 4'd0;
    endtask

    task automatic test_div();
        test_md_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        test_md_op(4'd4, 32'd7, 32'd0, "divu_zero");
        test_md_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    endtask

    task automatic test_moves();
        logic [31:0] v;
        start = 1'b1;
        op    = 4'd5;
        src_a = 32'h1234_5678;
        req   = 1'b1;
        @(negedge clk);
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mthi_req_busy: got %0b expected 0", busy);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (hi !== hi_m) begin
            failures++;
            $display("[TB] FAIL mthi_req_hi: got %h expected %h", hi, hi_m);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        hi_m = 32'h1234_5678;
        assertions++;
        if (hi !== hi_m) begin
            failures++;
            $display("[TB] FAIL mthi_hi: got %h expected %h", hi, hi_m);
        end
        op = 4'd8;
        #1;
        assertions++;
        if (out !== lo_m) begin
            failures++;
            $display("[TB] FAIL mflo_out: got %h expected %h", out, lo_m);
        end
        v     = $urandom;
        op    = 4'd6;
        src_a = v;
        @(posedge clk);
        #1;
        lo_m  = v;
        start = 1'b0;
        op    = 4'd8;
        #1;
        assertions++;
        if (lo !== lo_m || out !== lo_m) begin
            failures++;
            $display("[TB] FAIL mtlo_lo: got lo %h out %h expected %h", lo, out, lo_m);
        end
        op = 4'd0;
    endtask

    task automatic test_req_issue();
        start = 1'b1;
        op    = 4'd1;
        src_a = $urandom;
        src_b = $urandom;
        req   = 1'b1;
        #1;
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL req_issue_busy: got %0b expected 0", busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        req   = 1'b0;
        op    = 4'd0;
        for (int i = 0; i < MULT_CYCLES + 1; i++) begin
            @(negedge clk);
            assertions++;
            if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
                failures++;
                $display("[TB] FAIL req_issue_hold[%0d]: got busy %0b hi %h lo %h expected 0 %h %h",
                         i, busy, hi, lo, hi_m, lo_m);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        op    = 4'd5;
        src_a = 32'hA5A5_0001;
        @(posedge clk);
        #1;
        op    = 4'd6;
        src_a = 32'h5A5A_0002;
        @(posedge clk);
        #1;
        hi_m  = 32'hA5A5_0001;
        lo_m  = 32'h5A5A_0002;
        op    = 4'd3;
        src_a = $urandom;
        src_b = 32'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_busy: got %0b expected 0", busy);
        end
        assertions++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midreset_hilo: got %h/%h expected 0/0", hi, lo);
        end
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DIV_CYCLES + 2; i++) begin
            @(negedge clk);
            assertions++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                failures++;
                $display("[TB] FAIL midreset_quiet[%0d]: got busy %0b hi %h lo %h expected 0 0 0",
                         i, busy, hi, lo);
            end
        end
        @(posedge clk);
        #1;
        test_md_op(4'd1, $urandom, $urandom, "mult_after_reset");
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] a, b, exp_out;
        logic        r;
        for (int k = 0; k < 30; k++) begin
            o = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            if (o >= 4'd1 && o <= 4'd4) begin
                test_md_op(o, a, b, "rand_md");
            end else begin
                r     = 1'($urandom_range(0, 1));
                start = 1'b1;
                op    = o;
                src_a = a;
                src_b = b;
                req   = r;
                #1;
                exp_out = (o == 4'd7) ? hi_m : (o == 4'd8) ? lo_m : 32'd0;
                assertions++;
                if (busy !== 1'b0 || out !== exp_out) begin
                    failures++;
                    $display("[TB] FAIL rand_other op %0d: got busy %0b out %h expected 0 %h",
                             o, busy, out, exp_out);
                end
                @(posedge clk);
                #1;
                if (!r && o == 4'd5) hi_m = a;
                if (!r && o == 4'd6) lo_m = a;
                assertions++;
                if (hi !== hi_m || lo !== lo_m) begin
                    failures++;
                    $display("[TB] FAIL rand_other_hilo op %0d req %0b: got %h/%h expected %h/%h",
                             o, r, hi, lo, hi_m, lo_m);
                end
                start = 1'b0;
                req   = 1'b0;
                op    = 4'd0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_moves();
        test_req_issue();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
